// File: rtl/dec_to_num_pkg.sv
// Shared constants and state encoding for the 6-digit BCD-to-binary converter.
package dec_to_num_pkg;

  localparam int NDIG = 6;
  localparam int NBIN = 20;
  localparam int OUTW = 32;
  localparam int BCDW = NDIG * 4;
  localparam int SRW  = BCDW + NBIN;
  localparam int CNTW = $clog2(NBIN);

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic digitBad(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/dec_to_num_if.sv
// Request/response bundle between digit source and the converter.
interface dec_to_num_if;
  import dec_to_num_pkg::*;

  logic            start;
  logic [3:0]      inNum5;
  logic [3:0]      inNum4;
  logic [3:0]      inNum3;
  logic [3:0]      inNum2;
  logic [3:0]      inNum1;
  logic [3:0]      inNum0;
  logic            busy;
  logic            done;
  logic            err;
  logic [OUTW-1:0] outNum;

  modport master (
    output start, inNum5, inNum4, inNum3, inNum2, inNum1, inNum0,
    input  busy, done, err, outNum
  );

  modport slave (
    input  start, inNum5, inNum4, inNum3, inNum2, inNum1, inNum0,
    output busy, done, err, outNum
  );

endinterface

// File: rtl/dec_to_num_bcd_adj_nibble.sv
// Reverse double-dabble correction for one BCD nibble after a right shift.
module bcd_adj_nibble (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // A nibble >= 8 received a borrowed half-ten from the digit above; take back 3.
  always_comb begin
    if (nib >= 4'd8) begin
      adj = nib - 4'd3;
    end else begin
      adj = nib;
    end
  end

endmodule

// File: rtl/dec_to_num.sv
// Sequential BCD-to-binary converter: one reverse double-dabble step per clock,
// start/busy/done handshake, result zero-extended to the datapath width.
module dec_to_num
  import dec_to_num_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  dec_to_num_if.slave  bus
);

  state_e          state_r;
  state_e          nextState_s;
  logic [CNTW-1:0] cnt_r;
  logic [SRW-1:0]  shift_r;
  logic [SRW-1:0]  shifted_s;
  logic [SRW-1:0]  adjusted_s;
  logic [BCDW-1:0] digits_s;
  logic            anyBad_s;
  logic            lastIter_s;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic [OUTW-1:0] outNum_r;

  assign digits_s   = {bus.inNum5, bus.inNum4, bus.inNum3,
                       bus.inNum2, bus.inNum1, bus.inNum0};
  assign lastIter_s = (cnt_r == CNTW'(NBIN - 1));
  assign shifted_s  = {1'b0, shift_r[SRW-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : gAdj
    bcd_adj_nibble uAdj (
      .nib (shifted_s[NBIN + 4*g +: 4]),
      .adj (adjusted_s[NBIN + 4*g +: 4])
    );
  end
  assign adjusted_s[NBIN-1:0] = shifted_s[NBIN-1:0];

  // Flag a request carrying any non-decimal digit.
  always_comb begin
    anyBad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      anyBad_s = anyBad_s | digitBad(digits_s[4*i +: 4]);
    end
  end

  // Next-state decode.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          nextState_s = anyBad_s ? DONE : CONV;
        end else begin
          nextState_s = IDLE;
        end
      end
      CONV: begin
        if (lastIter_s) begin
          nextState_s = DONE;
        end else begin
          nextState_s = CONV;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register with busy/done decoded one edge early so they leave a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE);
      done_r  <= (nextState_s == DONE);
    end
  end

  // Shift register, iteration counter and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      shift_r  <= '0;
      err_r    <= 1'b0;
      outNum_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && anyBad_s) begin
            outNum_r <= '0;
            err_r    <= 1'b1;
          end else if (bus.start) begin
            shift_r <= {digits_s, {NBIN{1'b0}}};
            cnt_r   <= '0;
          end
        end
        CONV: begin
          shift_r <= adjusted_s;
          cnt_r   <= cnt_r + CNTW'(1);
          if (lastIter_s) begin
            outNum_r <= {{(OUTW-NBIN){1'b0}}, adjusted_s[NBIN-1:0]};
            err_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.outNum = outNum_r;

endmodule
